// File: rtl/inst_rom_loader.sv
// rtl/inst_rom_loader.sv - instruction ROM with combinational fetch port and byte-serial boot loader
module inst_rom_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce_i,
    input  logic [31:0]           addr_i,
    output logic [31:0]           inst_o,
    input  logic                  ld_start_i,
    input  logic                  ld_valid_i,
    input  logic [7:0]            ld_byte_i,
    input  logic                  ld_last_i,
    output logic                  ld_ready_o,
    output logic                  cpu_hold_o,
    output logic [ADDR_WIDTH:0]   ld_words_o,
    output logic                  ld_err_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [1:0]              cnt_q, cnt_d;
    logic [23:0]             shift_q, shift_d;
    logic [ADDR_WIDTH:0]     words_q, words_d;
    logic                    err_q, err_d;

    logic [31:0]             mem [DEPTH];
    logic                    mem_we;
    logic [31:0]             mem_wdata;
    logic                    accept;
    logic [ADDR_WIDTH-1:0]   rd_idx;
    logic                    unused_addr_bits;

    // Byte offset and high address bits are don't-care: the image aliases across the address space.
    assign rd_idx           = addr_i[ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^{addr_i[31:ADDR_WIDTH+2], addr_i[1:0]};

    // Fetch must land in the IF/ID register the same cycle, so the read is purely combinational.
    assign inst_o     = ce_i ? mem[rd_idx] : 32'h0;

    assign ld_ready_o = (state_q == LOAD);
    assign cpu_hold_o = (state_q == LOAD);
    assign ld_words_o = words_q;
    assign ld_err_o   = err_q;
    assign accept     = ld_valid_i & ld_ready_o;

    // Next-state logic: big-endian byte assembly, word commit, completion and overflow.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        words_d   = words_q;
        err_d     = err_q;
        mem_we    = 1'b0;
        mem_wdata = 32'h0;

        case (state_q)
            IDLE: begin
                if (ld_start_i) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                    cnt_d   = 2'd0;
                    shift_d = 24'h0;
                    words_d = '0;
                    err_d   = 1'b0;
                end
            end
            LOAD: begin
                if (accept) begin
                    if ((cnt_q == 2'd3) || ld_last_i) begin
                        mem_we = 1'b1;
                        // A short final word keeps its bytes at the top and zero-pads the rest.
                        case (cnt_q)
                            2'd0:    mem_wdata = {ld_byte_i, 24'h0};
                            2'd1:    mem_wdata = {shift_q[7:0], ld_byte_i, 16'h0};
                            2'd2:    mem_wdata = {shift_q[15:0], ld_byte_i, 8'h0};
                            default: mem_wdata = {shift_q, ld_byte_i};
                        endcase
                        ptr_d   = ptr_q + 1'b1;
                        words_d = words_q + 1'b1;
                        cnt_d   = 2'd0;
                        shift_d = 24'h0;
                        if (ld_last_i) begin
                            state_d = IDLE;
                        end else if (ptr_q == {ADDR_WIDTH{1'b1}}) begin
                            // Memory full and the image keeps coming: stop rather than wrap onto word 0.
                            state_d = IDLE;
                            err_d   = 1'b1;
                            ptr_d   = ptr_q;
                        end
                    end else begin
                        shift_d = {shift_q[15:0], ld_byte_i};
                        cnt_d   = cnt_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Loader state registers; reset discards any partially assembled word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= 2'd0;
            shift_q <= 24'h0;
            words_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            words_q <= words_d;
            err_q   <= err_d;
        end
    end

    // Memory write port; contents survive reset so a reset mid-load keeps completed words.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[ptr_q] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_inst_rom_loader.sv
// tb/tb_inst_rom_loader.sv - self-checking bench for inst_rom_loader
module tb_inst_rom_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce_i = 1'b0;
    logic [31:0] addr_i = 32'h0;
    logic [7:0]  ld_byte_i = 8'h0;
    logic        ld_last_i = 1'b0;

    logic        start1 = 1'b0, valid1 = 1'b0;
    logic [31:0] inst1;
    logic        ready1, hold1, err1;
    logic [10:0] words1;

    logic        start2 = 1'b0, valid2 = 1'b0;
    logic [31:0] inst2;
    logic        ready2, hold2, err2;
    logic [2:0]  words2;

    int errs = 0;
    int nchk = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic        ce;
        logic [31:0] addr;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[7];

    always #5 clk = ~clk;

    inst_rom_loader #(.ADDR_WIDTH(10)) u1 (
        .clk(clk), .rst(rst), .ce_i(ce_i), .addr_i(addr_i), .inst_o(inst1),
        .ld_start_i(start1), .ld_valid_i(valid1), .ld_byte_i(ld_byte_i), .ld_last_i(ld_last_i),
        .ld_ready_o(ready1), .cpu_hold_o(hold1), .ld_words_o(words1), .ld_err_o(err1)
    );

    inst_rom_loader #(.ADDR_WIDTH(2)) u2 (
        .clk(clk), .rst(rst), .ce_i(ce_i), .addr_i(addr_i), .inst_o(inst2),
        .ld_start_i(start2), .ld_valid_i(valid2), .ld_byte_i(ld_byte_i), .ld_last_i(ld_last_i),
        .ld_ready_o(ready2), .cpu_hold_o(hold2), .ld_words_o(words2), .ld_err_o(err2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send(input bit which, input logic [7:0] b, input logic last);
        ld_byte_i = b;
        ld_last_i = last;
        if (which) valid2 = 1'b1; else valid1 = 1'b1;
        tick();
        valid1 = 1'b0;
        valid2 = 1'b0;
        ld_last_i = 1'b0;
    endtask

    task automatic pulse_start(input bit which);
        if (which) start2 = 1'b1; else start1 = 1'b1;
        tick();
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        sbq.push_back(e);
    endtask

    task automatic drain(input bit which);
        exp_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            ce_i = 1'b1;
            addr_i = e.addr;
            #1;
            if (which) chk($sformatf("u2 fetch @%0h", e.addr), inst2, e.data);
            else       chk($sformatf("u1 fetch @%0h", e.addr), inst1, e.data);
        end
        ce_i = 1'b0;
        addr_i = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] img [8];
        img[0] = 8'h34; img[1] = 8'h02; img[2] = 8'h00; img[3] = 8'h01;
        img[4] = 8'h20; img[5] = 8'h42; img[6] = 8'h00; img[7] = 8'h02;

        vecs[0] = '{1'b1, 32'h0000_0000, 32'h3402_0001};
        vecs[1] = '{1'b1, 32'h0000_0004, 32'h2042_0002};
        vecs[2] = '{1'b1, 32'h0000_0001, 32'h3402_0001};
        vecs[3] = '{1'b1, 32'h0000_0007, 32'h2042_0002};
        vecs[4] = '{1'b1, 32'h0000_1000, 32'h3402_0001};
        vecs[5] = '{1'b1, 32'hFFFF_F004, 32'h2042_0002};
        vecs[6] = '{1'b0, 32'h0000_0004, 32'h0000_0000};

        // reset state
        tick();
        tick();
        chk("rst inst", inst1, 32'h0);
        chk("rst hold", hold1, 1'b0);
        chk("rst ready", ready1, 1'b0);
        chk("rst words", words1, 11'd0);
        chk("rst err", err1, 1'b0);
        rst = 1'b0;
        tick();
        chk("idle hold", hold1, 1'b0);

        // two-word image, last on final byte
        pulse_start(1'b0);
        chk("load hold", hold1, 1'b1);
        chk("load ready", ready1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            send(1'b0, img[i], i == 7);
            if (i < 7) chk($sformatf("hold byte%0d", i), hold1, 1'b1);
        end
        chk("img hold done", hold1, 1'b0);
        chk("img ready done", ready1, 1'b0);
        chk("img words", words1, 11'd2);
        for (int i = 0; i < 7; i++) begin
            ce_i = vecs[i].ce;
            addr_i = vecs[i].addr;
            #1;
            chk($sformatf("vec%0d", i), inst1, vecs[i].exp);
        end
        ce_i = 1'b0;

        // partial final word is zero padded
        pulse_start(1'b0);
        send(1'b0, 8'hAA, 1'b0);
        send(1'b0, 8'hBB, 1'b1);
        chk("partial words", words1, 11'd1);
        chk("partial hold", hold1, 1'b0);
        chk("partial ready", ready1, 1'b0);
        push(32'h0, 32'hAABB_0000);
        push(32'h4, 32'h2042_0002);
        drain(1'b0);

        // gaps, ignored restart and stray last
        pulse_start(1'b0);
        send(1'b0, img[0], 1'b0);
        repeat (3) tick();
        chk("gap hold", hold1, 1'b1);
        send(1'b0, img[1], 1'b0);
        pulse_start(1'b0);
        chk("restart ignored ready", ready1, 1'b1);
        send(1'b0, img[2], 1'b0);
        send(1'b0, img[3], 1'b0);
        chk("gap words1", words1, 11'd1);
        ld_last_i = 1'b1;
        repeat (3) tick();
        ld_last_i = 1'b0;
        chk("stray last hold", hold1, 1'b1);
        chk("stray last words", words1, 11'd1);
        for (int i = 4; i < 8; i++) send(1'b0, img[i], i == 7);
        chk("gap words2", words1, 11'd2);
        chk("gap hold done", hold1, 1'b0);
        push(32'h0, 32'h3402_0001);
        push(32'h4, 32'h2042_0002);
        drain(1'b0);

        // same-cycle read returns old word, then reset mid-load
        pulse_start(1'b0);
        send(1'b0, 8'h11, 1'b0);
        send(1'b0, 8'h22, 1'b0);
        send(1'b0, 8'h33, 1'b0);
        ce_i = 1'b1;
        addr_i = 32'h0;
        ld_byte_i = 8'h44;
        valid1 = 1'b1;
        #1;
        chk("read during write", inst1, 32'h3402_0001);
        tick();
        valid1 = 1'b0;
        chk("read after write", inst1, 32'h1122_3344);
        ce_i = 1'b0;
        send(1'b0, 8'h55, 1'b0);
        send(1'b0, 8'h66, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst hold", hold1, 1'b0);
        chk("midrst ready", ready1, 1'b0);
        chk("midrst words", words1, 11'd0);
        push(32'h0, 32'h1122_3344);
        push(32'h4, 32'h2042_0002);
        drain(1'b0);

        // overflow on the 4-word instance
        pulse_start(1'b1);
        for (int i = 0; i < 20; i++) begin
            send(1'b1, 8'(i), 1'b0);
            if (i == 14) begin
                chk("ovf err pre", err2, 1'b0);
                chk("ovf ready pre", ready2, 1'b1);
            end
            if (i == 15) begin
                chk("ovf err", err2, 1'b1);
                chk("ovf ready", ready2, 1'b0);
            end
        end
        chk("ovf words", words2, 3'd4);
        chk("ovf err sticky", err2, 1'b1);
        chk("ovf ready after", ready2, 1'b0);
        chk("ovf hold after", hold2, 1'b0);
        push(32'h0, 32'h0001_0203);
        push(32'h4, 32'h0405_0607);
        push(32'h8, 32'h0809_0A0B);
        push(32'hC, 32'h0C0D_0E0F);
        push(32'h10, 32'h0001_0203);
        drain(1'b1);
        pulse_start(1'b1);
        chk("restart clears err", err2, 1'b0);
        chk("restart clears words", words2, 3'd0);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule

// File: doc/inst_rom_loader.md
Name: inst_rom_loader

Overview:
- Instruction-memory responder for the processor's fetch port. It answers the core's rom_ce_o/rom_addr_o with rom_data_i, using a combinational read so that the IF/ID register captures the word in the same cycle.
- Adds a byte-serial boot-load port that fills the memory with big-endian MIPS words.
- Holds the core in reset while a load is in progress.
- Sits beside the processor top level in the SoC wrapper.

Parameters:
- ADDR_WIDTH, 10: word-address bits; DEPTH = 2**ADDR_WIDTH words of 32 bits.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- ce_i  in  1  fetch enable (from core rom_ce_o)
- addr_i  in  32  byte address (from core rom_addr_o)
- inst_o  out  32  instruction word (to core rom_data_i)
- ld_start_i  in  1  one-cycle pulse that begins a load
- ld_valid_i  in  1  ld_byte_i is valid
- ld_byte_i  in  8  load data byte
- ld_last_i  in  1  qualifies the final byte of the image
- ld_ready_o  out  1  loader accepts a byte this cycle
- cpu_hold_o  out  1  drive the core's reset; high while loading
- ld_words_o  out  ADDR_WIDTH+1  count of words written by the last/current load
- ld_err_o  out  1  sticky overflow flag

Behaviour:
- Clocking and reset:
  - One clock, clk. rst is synchronous and active-high, sampled on posedge clk.
  - On reset: state=IDLE, ld_ready_o=0, cpu_hold_o=0, ld_words_o=0, ld_err_o=0, byte counter=0, shift register=0.
  - Memory array contents are NOT cleared by reset.
- Fetch side (combinational, 0-cycle latency):
  - Word index = addr_i[ADDR_WIDTH+1:2]. addr_i[1:0] and the bits above ADDR_WIDTH+1 are ignored, so addresses alias.
  - inst_o = mem[index] when ce_i=1; inst_o = 32'h0 when ce_i=0 (including during reset, because the core drops ce).
  - Fetch is serviced in every state.
  - A word written at edge N is visible on inst_o after edge N; a read in the same cycle as the write returns the old data.
- Load FSM states: IDLE, LOAD.
  - IDLE, ld_start_i=1: go to LOAD; clear word pointer, byte counter, ld_words_o and ld_err_o.
  - LOAD: ld_ready_o=1 and cpu_hold_o=1. Both are decoded from the registered state, so they rise the cycle after the start pulse.
  - A byte is accepted when ld_valid_i & ld_ready_o.
  - Byte order is big-endian: the 1st byte fills [31:24], the 4th fills [7:0].
  - On acceptance of the 4th byte: at that edge write {shift[23:0], ld_byte_i} to mem[ptr], then ptr+1, ld_words_o+1, byte counter=0.
  - ld_last_i with an accepted byte ending a partial word (1–3 bytes): write the word with the unfilled low bytes zero-padded, count it, and go to IDLE at the same edge.
  - ld_last_i on the 4th byte: normal write, then go to IDLE.
  - In LOAD, ld_valid_i=0: hold all state. ld_last_i without ld_valid_i is ignored.
  - ld_start_i during LOAD is ignored.
- Overflow:
  - When the word at ptr = DEPTH-1 is written without ld_last_i: set ld_err_o=1, go to IDLE, do not wrap.
  - No further bytes are accepted; ld_err_o stays set until the next ld_start_i or rst.
- Completion: cpu_hold_o falls the cycle after the final write edge. The core then leaves reset and fetches from address 0 holding the new image.
- Reset mid-load: returns to IDLE, cpu_hold_o=0, counters cleared. Words already written are retained; a partial word is discarded.

Test Plan:
- Reset, ce_i=0, addr_i=0 -> inst_o=0, cpu_hold_o=0, ld_ready_o=0, ld_words_o=0.
- Start pulse, then bytes 34 02 00 01 20 42 00 02 with ld_last_i on the final byte -> cpu_hold_o high from cycle+1 until the cycle after the last byte. With ce_i=1: addr 0 -> 32'h34020001, addr 4 -> 32'h20420002, ld_words_o=2.
- Bytes AA BB with ld_last_i on BB -> mem[0]=32'hAABB0000, ld_words_o=1, FSM returns to IDLE.
- Hold ld_valid_i low for 3 cycles between bytes, and pulse ld_start_i mid-load -> image identical to the gap-free run, no restart.
- ADDR_WIDTH=2, feed 20 bytes without ld_last_i -> ld_err_o=1 after the 16th byte, ld_words_o=4, ld_ready_o=0 afterwards; addr 16 aliases to mem[0].
- Assert rst after 6 bytes -> mem[0] holds the first 4 bytes, mem[1] unchanged, cpu_hold_o=0, ld_words_o=0 the next cycle.
